// File: rtl/xsimbus_rr_arbiter_pkg.sv
// Shared types and constants for the xSimBus round-robin arbiter.
package xsimbus_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StGrant  = 2'd1,
      StLocked = 2'd2
   } state_e;

   localparam logic RwRead  = 1'b0;
   localparam logic RwWrite = 1'b1;

   localparam logic DeviceSelect = 1'b1;
   localparam logic DeviceNotSel = 1'b0;

   // Bus address presented while nothing is granted.
   localparam logic [63:0] ResetAddr = 64'h0;

   localparam int unsigned HoldW = 8;

   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 == n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/xsimbus_rr_pick.sv
// Masked round-robin priority encoder: first candidate at or after ptr, wrapping to 0.
module xsimbus_rr_pick #(
   parameter int unsigned N    = 4,
   parameter int unsigned IdxW = 2
) (
   input  logic [N-1:0]    req,
   input  logic [IdxW-1:0] ptr,
   input  logic [N-1:0]    excl,
   output logic [N-1:0]    onehot,
   output logic [IdxW-1:0] idx,
   output logic            found
);

   logic [N-1:0]    cand;
   logic [IdxW-1:0] pos;

   assign cand = req & ~excl;

   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      pos    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = IdxW'((32'(ptr) + k) % N);
         if (!found && cand[pos]) begin
            found       = 1'b1;
            onehot[pos] = 1'b1;
            idx         = pos;
         end
      end
   end

endmodule

// File: rtl/xsimbus_rr_arbiter.sv
// Round-robin xSimBus arbiter with burst lock, address decode and read-data mux.
// Define XSIMBUS_ARB_TIMEOUT_EN to compile in the MAX_HOLD forced-rotation counter.
module xsimbus_rr_arbiter
   import xsimbus_rr_arbiter_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DEV_ID_W    = 5,
   parameter int unsigned MAX_HOLD    = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_MASTERS-1:0]              req_in,
   input  logic [NUM_MASTERS-1:0]              lock_in,
   input  logic [NUM_MASTERS-1:0]              rw_in,
   input  logic [NUM_MASTERS*ADDR_W-1:0]       addr_in,
   input  logic [NUM_MASTERS*DATA_W-1:0]       wdata_in,
   input  logic [(1 << DEV_ID_W)*DATA_W-1:0]   rdata_in,
   output logic [NUM_MASTERS-1:0]              grant_out,
   output logic [4:0]                          master_id_out,
   output logic [DEV_ID_W-1:0]                 device_id_out,
   output logic [ADDR_W-1:0]                   device_addr_out,
   output logic                                rw_out,
   output logic [DATA_W-1:0]                   wdata_out,
   output logic [DATA_W-1:0]                   rdata_out,
   output logic                                valid_out,
   output logic [NUM_MASTERS-1:0]              stall_out
);

   localparam int unsigned IdxW   = $clog2(NUM_MASTERS);
   localparam int unsigned NumDev = 1 << DEV_ID_W;

   if (NUM_MASTERS < 2 || NUM_MASTERS > 32) begin : gen_bad_masters
      $error("NUM_MASTERS must be 2..32");
   end
   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : gen_bad_hold
      $error("MAX_HOLD must be 1..255");
   end

   state_e                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IdxW-1:0]        idx_q, idx_d;
   logic [IdxW-1:0]        ptr_q, ptr_d;
`ifdef XSIMBUS_ARB_TIMEOUT_EN
   logic [HoldW-1:0]       hold_q, hold_d;
`endif

   logic [NUM_MASTERS-1:0] pick_onehot;
   logic [IdxW-1:0]        pick_idx;
   logic                   pick_found;
   logic                   take_pick, go_idle;
   logic                   cur_req, cur_lock;

   // Excluding the current holder covers both release and forced rotation; idle excludes nobody.
   xsimbus_rr_pick #(
      .N    (NUM_MASTERS),
      .IdxW (IdxW)
   ) u_pick (
      .req    (req_in),
      .ptr    (ptr_q),
      .excl   (grant_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .found  (pick_found)
   );

   assign cur_req  = req_in[idx_q];
   assign cur_lock = lock_in[idx_q];

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
`ifdef XSIMBUS_ARB_TIMEOUT_EN
      hold_d    = hold_q;
`endif
      take_pick = 1'b0;
      go_idle   = 1'b0;

      unique case (state_q)
         StIdle: begin
            take_pick = pick_found;
         end
         StGrant: begin
            if (!cur_req) begin
               take_pick = pick_found;
               go_idle   = !pick_found;
            end else if (cur_lock) begin
               state_d = StLocked;
`ifdef XSIMBUS_ARB_TIMEOUT_EN
            end else if (|stall_out) begin
               if (hold_q >= HoldW'(MAX_HOLD - 1)) begin
                  take_pick = 1'b1;
               end else if (hold_q != '1) begin
                  hold_d = hold_q + 1'b1;
               end
`endif
            end
         end
         StLocked: begin
            if (!cur_req && !cur_lock) begin
               take_pick = pick_found;
               go_idle   = !pick_found;
            end else if (!cur_lock) begin
               state_d = StGrant;
`ifdef XSIMBUS_ARB_TIMEOUT_EN
               hold_d  = '0;
`endif
            end
         end
         default: begin
            go_idle = 1'b1;
         end
      endcase

      if (take_pick) begin
         state_d = StGrant;
         grant_d = pick_onehot;
         idx_d   = pick_idx;
         ptr_d   = IdxW'(wrap_inc(32'(pick_idx), NUM_MASTERS));
`ifdef XSIMBUS_ARB_TIMEOUT_EN
         hold_d  = '0;
`endif
      end
      if (go_idle) begin
         state_d = StIdle;
         grant_d = '0;
         idx_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
`ifdef XSIMBUS_ARB_TIMEOUT_EN
         hold_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
`ifdef XSIMBUS_ARB_TIMEOUT_EN
         hold_q  <= hold_d;
`endif
      end
   end

   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] wdata_mux, rdata_mux;
   logic              rw_mux;
   logic [NumDev-1:0] dev_sel;

   always_comb begin
      addr_mux  = ADDR_W'(ResetAddr);
      wdata_mux = '0;
      rw_mux    = RwRead;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (grant_q[i]) begin
            addr_mux  = addr_in[i*ADDR_W +: ADDR_W];
            wdata_mux = wdata_in[i*DATA_W +: DATA_W];
            rw_mux    = (rw_in[i] == RwWrite) ? RwWrite : RwRead;
         end
      end
   end

   always_comb begin
      rdata_mux = '0;
      dev_sel   = '0;
      for (int unsigned d = 0; d < NumDev; d++) begin
         dev_sel[d] = (valid_out && device_id_out == DEV_ID_W'(d)) ? DeviceSelect : DeviceNotSel;
         if (dev_sel[d] == DeviceSelect) begin
            rdata_mux = rdata_in[d*DATA_W +: DATA_W];
         end
      end
   end

   assign grant_out       = grant_q;
   assign master_id_out   = 5'(idx_q);
   assign valid_out       = |grant_q;
   assign stall_out       = req_in & ~grant_q;
   assign device_addr_out = addr_mux;
   assign device_id_out   = addr_mux[ADDR_W-1 -: DEV_ID_W];
   assign rw_out          = rw_mux;
   assign wdata_out       = wdata_mux;
   assign rdata_out       = rdata_mux;

endmodule

// File: tb/tb_xsimbus_rr_arbiter.sv
// Randomised and directed bench for xsimbus_rr_arbiter against a behavioural owner/queue model.
module tb_xsimbus_rr_arbiter;

   localparam int unsigned NM = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned IW = 5;
   localparam int unsigned ND = 32;
   localparam int unsigned MH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [NM-1:0] req, lock, rw;
   logic [AW-1:0] addr  [NM];
   logic [DW-1:0] wdata [NM];
   logic [DW-1:0] rdata [ND];

   logic [NM*AW-1:0] addr_bus;
   logic [NM*DW-1:0] wdata_bus;
   logic [ND*DW-1:0] rdata_bus;

   always_comb begin
      addr_bus  = '0;
      wdata_bus = '0;
      rdata_bus = '0;
      for (int i = 0; i < NM; i++) begin
         addr_bus[i*AW +: AW]  = addr[i];
         wdata_bus[i*DW +: DW] = wdata[i];
      end
      for (int d = 0; d < ND; d++) rdata_bus[d*DW +: DW] = rdata[d];
   end

   logic [NM-1:0] grant_out, stall_out;
   logic [4:0]    master_id_out;
   logic [IW-1:0] device_id_out;
   logic [AW-1:0] device_addr_out;
   logic          rw_out, valid_out;
   logic [DW-1:0] wdata_out, rdata_out;

   xsimbus_rr_arbiter #(
      .NUM_MASTERS (NM),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .DEV_ID_W    (IW),
      .MAX_HOLD    (MH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req_in          (req),
      .lock_in         (lock),
      .rw_in           (rw),
      .addr_in         (addr_bus),
      .wdata_in        (wdata_bus),
      .rdata_in        (rdata_bus),
      .grant_out       (grant_out),
      .master_id_out   (master_id_out),
      .device_id_out   (device_id_out),
      .device_addr_out (device_addr_out),
      .rw_out          (rw_out),
      .wdata_out       (wdata_out),
      .rdata_out       (rdata_out),
      .valid_out       (valid_out),
      .stall_out       (stall_out)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: who owns the bus, whether it is locked, where the scan starts next.
   int m_owner  = -1;
   int m_ptr    = 0;
   int m_hold   = 0;
   bit m_locked = 1'b0;

   function automatic logic [NM-1:0] onehot(input int o);
      logic [NM-1:0] v;
      v    = '0;
      v[o] = 1'b1;
      return v;
   endfunction

   function automatic int rr_pick(input logic [NM-1:0] r, input int from, input int skip);
      for (int k = 0; k < NM; k++) begin
         int j;
         j = (from + k) % NM;
         if (r[j] && j != skip) return j;
      end
      return -1;
   endfunction

   task automatic model_grant(input int p);
      if (p < 0) begin
         m_owner  = -1;
         m_locked = 1'b0;
      end else begin
         m_owner  = p;
         m_ptr    = (p + 1) % NM;
         m_hold   = 0;
         m_locked = 1'b0;
      end
   endtask

   task automatic model_step();
      if (!rst) begin
         m_owner  = -1;
         m_ptr    = 0;
         m_hold   = 0;
         m_locked = 1'b0;
      end else if (m_owner < 0) begin
         if (rr_pick(req, m_ptr, -1) >= 0) model_grant(rr_pick(req, m_ptr, -1));
      end else if (m_locked) begin
         if (!req[m_owner] && !lock[m_owner]) begin
            model_grant(rr_pick(req, m_ptr, m_owner));
         end else if (!lock[m_owner]) begin
            m_locked = 1'b0;
            m_hold   = 0;
         end
      end else begin
         if (!req[m_owner]) begin
            model_grant(rr_pick(req, m_ptr, m_owner));
         end else if (lock[m_owner]) begin
            m_locked = 1'b1;
`ifdef XSIMBUS_ARB_TIMEOUT_EN
         end else if ((req & ~onehot(m_owner)) != '0) begin
            m_hold++;
            if (m_hold >= MH) model_grant(rr_pick(req, m_ptr, m_owner));
`endif
         end
      end
   endtask

   task automatic compare_all();
      logic [NM-1:0] exp_g;
      logic [AW-1:0] exp_a;
      logic [DW-1:0] exp_w, exp_r;
      logic [IW-1:0] exp_d;
      logic          exp_rw;
      exp_g  = '0;
      exp_a  = '0;
      exp_w  = '0;
      exp_r  = '0;
      exp_rw = 1'b0;
      if (m_owner >= 0) begin
         exp_g  = onehot(m_owner);
         exp_a  = addr[m_owner];
         exp_w  = wdata[m_owner];
         exp_rw = rw[m_owner];
      end
      exp_d = exp_a[AW-1 -: IW];
      if (m_owner >= 0) exp_r = rdata[exp_d];
      check_eq("grant", grant_out, exp_g);
      check_eq("valid", valid_out, m_owner >= 0);
      check_eq("stall", stall_out, req & ~exp_g);
      check_eq("master_id", master_id_out, (m_owner >= 0) ? m_owner : 0);
      check_eq("dev_addr", device_addr_out, exp_a);
      check_eq("dev_id", device_id_out, exp_d);
      check_eq("rdata", rdata_out, exp_r);
      check_eq("wdata", wdata_out, exp_w);
      check_eq("rw", rw_out, exp_rw);
   endtask

   task automatic sample();
      @(negedge clk);
      compare_all();
   endtask

   task automatic step_clk();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic cyc();
      sample();
      step_clk();
   endtask

   initial begin
      rst  = 1'b0;
      req  = 4'hF;
      lock = '0;
      rw   = '0;
      for (int i = 0; i < NM; i++) begin
         addr[i]  = '0;
         wdata[i] = $urandom;
      end
      for (int d = 0; d < ND; d++) rdata[d] = $urandom;

      // Reset with everyone requesting, then release.
      cyc();
      cyc();
      sample();
      check_eq("rst_grant", grant_out, 4'h0);
      check_eq("rst_valid", valid_out, 1'b0);
      check_eq("rst_stall", stall_out, 4'hF);
      step_clk();
      rst = 1'b1;
      cyc();
      sample();
      check_eq("rel_grant", grant_out, 4'b0001);
      step_clk();

      // Fairness: holder drops its request for one cycle after being granted.
      for (int k = 0; k < 5; k++) begin
         req = 4'hF & ~onehot(k % NM);
         sample();
         check_eq("fair_order", grant_out, onehot(k % NM));
         step_clk();
      end

      // Hold-limit rotation.
      req = '0;
      cyc();
      cyc();
      req = 4'b0010;
      cyc();
      req = 4'b0110;
      for (int k = 0; k < MH; k++) begin
         sample();
         check_eq("hold_keep", grant_out, 4'b0010);
         step_clk();
      end
      sample();
`ifdef XSIMBUS_ARB_TIMEOUT_EN
      check_eq("hold_rotate", grant_out, 4'b0100);
      step_clk();
`else
      check_eq("hold_forever", grant_out, 4'b0010);
      step_clk();
      for (int k = 0; k < 12; k++) begin
         sample();
         check_eq("hold_forever", grant_out, 4'b0010);
         step_clk();
      end
`endif

      // Burst lock blocks rotation.
      req = '0;
      cyc();
      cyc();
      req  = 4'b0001;
      lock = 4'b0001;
      cyc();
      req = 4'b1001;
      for (int k = 0; k < 20; k++) begin
         sample();
         check_eq("lock_hold", grant_out, 4'b0001);
         step_clk();
      end
      req  = 4'b1000;
      lock = '0;
      cyc();
      sample();
      check_eq("lock_release", grant_out, 4'b1000);
      step_clk();

      // Address decode and read-data mux.
      req = '0;
      cyc();
      cyc();
      addr[2]  = 32'h1000_0040;
      rdata[2] = 32'hDEAD_BEEF;
      req      = 4'b0100;
      cyc();
      sample();
      check_eq("dec_dev2", device_id_out, 2);
      check_eq("dec_rdata2", rdata_out, 32'hDEAD_BEEF);
      step_clk();
      addr[2]   = 32'hF800_0000;
      rdata[31] = 32'h0BAD_F00D;
      sample();
      check_eq("dec_dev31", device_id_out, 31);
      check_eq("dec_rdata31", rdata_out, 32'h0BAD_F00D);
      step_clk();

      // Back-to-back handover with no idle bubble.
      req = 4'b0001;
      cyc();
      sample();
      check_eq("b2b_first", grant_out, 4'b0001);
      req = 4'b0100;
      step_clk();
      sample();
      check_eq("b2b_second", grant_out, 4'b0100);
      check_eq("b2b_valid", valid_out, 1'b1);
      step_clk();

      // Randomised traffic with occasional locks and resets.
      for (int c = 0; c < 3000; c++) begin
         int m;
         rst = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         if ($urandom_range(0, 7) == 0) lock = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         rw       = 4'($urandom);
         m        = $urandom_range(0, NM - 1);
         addr[m]  = $urandom;
         wdata[m] = $urandom;
         rdata[$urandom_range(0, ND - 1)] = $urandom;
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
